rob_commit: RTL

//  Reorder buffer downstream of the RSBRA/BRA branch path and the ALU CDB. Allocates one tag per issued

---
 rtl/rob_commit_if.sv | 50 +++++
 rtl/rob_commit.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/rob_commit_if.sv
// Bundles the reorder buffer's issue, writeback, operand-query and commit/flush signals.
// The slave modport is the ROB itself; the master modport is the surrounding core (or a bench).
interface rob_commit_if #(
    parameter int ENTRY_W = 3
);
    // Issue / allocation
    logic               issue_we;
    logic [4:0]         issue_rd;
    logic               issue_is_branch;
    logic [ENTRY_W-1:0] issue_tag;
    logic               full;
    logic               empty;
    // ALU common data bus
    logic [ENTRY_W-1:0] CDB_ALU_ROB_index;
    logic [31:0]        CDB_ALU_data;
    // Branch unit result
    logic [ENTRY_W-1:0] BRA_Dest_out;
    logic [31:0]        BRA_Dest_val;
    logic               Jump_en;
    logic [31:0]        JumpAddr;
    // Operand lookup
    logic [ENTRY_W-1:0] Q_query;
    logic               Q_ready;
    logic [31:0]        Q_value;
    // Commit / redirect
    logic               commit_we;
    logic [4:0]         commit_rd;
    logic [31:0]        commit_data;
    logic [ENTRY_W-1:0] commit_tag;
    logic               flush;
    logic [31:0]        flush_PC;

    modport slave (
        input  issue_we, issue_rd, issue_is_branch,
        input  CDB_ALU_ROB_index, CDB_ALU_data,
        input  BRA_Dest_out, BRA_Dest_val, Jump_en, JumpAddr,
        input  Q_query,
        output issue_tag, full, empty, Q_ready, Q_value,
        output commit_we, commit_rd, commit_data, commit_tag, flush, flush_PC
    );

    modport master (
        output issue_we, issue_rd, issue_is_branch,
        output CDB_ALU_ROB_index, CDB_ALU_data,
        output BRA_Dest_out, BRA_Dest_val, Jump_en, JumpAddr,
        output Q_query,
        input  issue_tag, full, empty, Q_ready, Q_value,
        input  commit_we, commit_rd, commit_data, commit_tag, flush, flush_PC
    );
endinterface

// File: rtl/rob_commit.sv
// Reorder buffer: allocates a tag per issued instruction, captures ALU/BRA results by tag,
// retires in order one per cycle, and flushes everything when a taken branch retires.
// Tag 0 means "no tag"; entry slot 0 exists only so tags index the arrays directly and is never valid.
module rob_commit #(
    parameter int ENTRY_W = 3
) (
    input  logic         clk,
    input  logic         rst,
    rob_commit_if.slave  bus
);
    localparam int                 DEPTH     = 1 << ENTRY_W;
    localparam logic [ENTRY_W-1:0] LAST_TAG  = {ENTRY_W{1'b1}};
    localparam logic [ENTRY_W-1:0] FIRST_TAG = {{(ENTRY_W-1){1'b0}}, 1'b1};

    // Tags wrap from the last usable tag back to 1, skipping the reserved 0.
    function automatic logic [ENTRY_W-1:0] tag_inc(input logic [ENTRY_W-1:0] t);
        return (t == LAST_TAG) ? FIRST_TAG : t + 1'b1;
    endfunction

    // Entry storage
    logic        valid_q     [DEPTH];
    logic        valid_d     [DEPTH];
    logic        ready_q     [DEPTH];
    logic        ready_d     [DEPTH];
    logic        is_branch_q [DEPTH];
    logic        is_branch_d [DEPTH];
    logic        taken_q     [DEPTH];
    logic        taken_d     [DEPTH];
    logic [4:0]  rd_q        [DEPTH];
    logic [4:0]  rd_d        [DEPTH];
    logic [31:0] value_q     [DEPTH];
    logic [31:0] value_d     [DEPTH];
    logic [31:0] target_q    [DEPTH];
    logic [31:0] target_d    [DEPTH];

    // Pointers, occupancy and registered outputs
    logic [ENTRY_W-1:0] head_q, head_d;
    logic [ENTRY_W-1:0] tail_q, tail_d;
    logic [ENTRY_W-1:0] count_q, count_d;
    logic               commit_we_q, commit_we_d;
    logic [4:0]         commit_rd_q, commit_rd_d;
    logic [31:0]        commit_data_q, commit_data_d;
    logic [ENTRY_W-1:0] commit_tag_q, commit_tag_d;
    logic               flush_q, flush_d;
    logic [31:0]        flush_pc_q, flush_pc_d;

    logic [DEPTH-1:0] alu_hit;
    logic [DEPTH-1:0] bra_hit;
    logic             full_w;
    logic             retire;
    logic             flush_now;
    logic             alloc;

    // Per-entry writeback decode: a broadcast only lands on a currently valid entry.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
            assign alu_hit[gi] = valid_q[gi] && (bus.CDB_ALU_ROB_index == ENTRY_W'(gi));
            assign bra_hit[gi] = valid_q[gi] && (bus.BRA_Dest_out == ENTRY_W'(gi));
        end
    endgenerate

    assign full_w    = (count_q == LAST_TAG);
    assign retire    = valid_q[head_q] & ready_q[head_q];
    assign flush_now = retire & is_branch_q[head_q] & taken_q[head_q];
    // A flush on this edge or in this cycle discards any issue attempt.
    assign alloc     = bus.issue_we & ~full_w & ~flush_q & ~flush_now;

    // Entry next-state: writebacks (BRA last so it wins), then retire, allocate, and flush override.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            valid_d[i]     = valid_q[i];
            ready_d[i]     = ready_q[i];
            is_branch_d[i] = is_branch_q[i];
            taken_d[i]     = taken_q[i];
            rd_d[i]        = rd_q[i];
            value_d[i]     = value_q[i];
            target_d[i]    = target_q[i];
            if (alu_hit[i]) begin
                ready_d[i] = 1'b1;
                value_d[i] = bus.CDB_ALU_data;
            end
            if (bra_hit[i]) begin
                ready_d[i]  = 1'b1;
                value_d[i]  = bus.BRA_Dest_val;
                taken_d[i]  = bus.Jump_en;
                target_d[i] = bus.JumpAddr;
            end
            if (retire && (head_q == ENTRY_W'(i))) begin
                valid_d[i] = 1'b0;
            end
            if (alloc && (tail_q == ENTRY_W'(i))) begin
                valid_d[i]     = 1'b1;
                ready_d[i]     = 1'b0;
                is_branch_d[i] = bus.issue_is_branch;
                taken_d[i]     = 1'b0;
                rd_d[i]        = bus.issue_rd;
            end
            if (flush_now) begin
                valid_d[i] = 1'b0;
            end
        end
    end

    // Entry registers.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (rst) begin
                valid_q[i]     <= 1'b0;
                ready_q[i]     <= 1'b0;
                is_branch_q[i] <= 1'b0;
                taken_q[i]     <= 1'b0;
                rd_q[i]        <= 5'd0;
                value_q[i]     <= 32'd0;
                target_q[i]    <= 32'd0;
            end else begin
                valid_q[i]     <= valid_d[i];
                ready_q[i]     <= ready_d[i];
                is_branch_q[i] <= is_branch_d[i];
                taken_q[i]     <= taken_d[i];
                rd_q[i]        <= rd_d[i];
                value_q[i]     <= value_d[i];
                target_q[i]    <= target_d[i];
            end
        end
    end

    // Pointer/count update and registered commit/flush outputs.
    always_comb begin
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        commit_we_d   = 1'b0;
        commit_rd_d   = commit_rd_q;
        commit_data_d = commit_data_q;
        commit_tag_d  = commit_tag_q;
        flush_d       = 1'b0;
        flush_pc_d    = 32'd0;
        if (retire) begin
            head_d        = tag_inc(head_q);
            commit_we_d   = (rd_q[head_q] != 5'd0);
            commit_rd_d   = rd_q[head_q];
            commit_data_d = value_q[head_q];
            commit_tag_d  = head_q;
        end
        if (alloc) begin
            tail_d = tag_inc(tail_q);
        end
        case ({alloc, retire})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (flush_now) begin
            flush_d    = 1'b1;
            flush_pc_d = target_q[head_q];
            head_d     = FIRST_TAG;
            tail_d     = FIRST_TAG;
            count_d    = '0;
        end
    end

    // Control registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q        <= FIRST_TAG;
            tail_q        <= FIRST_TAG;
            count_q       <= '0;
            commit_we_q   <= 1'b0;
            commit_rd_q   <= 5'd0;
            commit_data_q <= 32'd0;
            commit_tag_q  <= '0;
            flush_q       <= 1'b0;
            flush_pc_q    <= 32'd0;
        end else begin
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            commit_we_q   <= commit_we_d;
            commit_rd_q   <= commit_rd_d;
            commit_data_q <= commit_data_d;
            commit_tag_q  <= commit_tag_d;
            flush_q       <= flush_d;
            flush_pc_q    <= flush_pc_d;
        end
    end

    // Operand lookup with same-cycle broadcast bypass (BRA has priority, as on writeback).
    always_comb begin
        bus.Q_ready = 1'b0;
        bus.Q_value = 32'd0;
        if (bus.Q_query == '0) begin
            bus.Q_ready = 1'b1;
        end else if (valid_q[bus.Q_query]) begin
            if (bus.BRA_Dest_out == bus.Q_query) begin
                bus.Q_ready = 1'b1;
                bus.Q_value = bus.BRA_Dest_val;
            end else if (bus.CDB_ALU_ROB_index == bus.Q_query) begin
                bus.Q_ready = 1'b1;
                bus.Q_value = bus.CDB_ALU_data;
            end else begin
                bus.Q_ready = ready_q[bus.Q_query];
                bus.Q_value = value_q[bus.Q_query];
            end
        end
    end

    assign bus.issue_tag   = tail_q;
    assign bus.full        = full_w;
    assign bus.empty       = (count_q == '0);
    assign bus.commit_we   = commit_we_q;
    assign bus.commit_rd   = commit_rd_q;
    assign bus.commit_data = commit_data_q;
    assign bus.commit_tag  = commit_tag_q;
    assign bus.flush       = flush_q;
    assign bus.flush_PC    = flush_pc_q;
endmodule
